// File: rtl/biquad_pkg.sv
// Shared constants, FSM state type and saturation helper for the biquad cascade.
package biquad_pkg;

  localparam int B0 = 0;
  localparam int B1 = 1;
  localparam int B2 = 2;
  localparam int A1 = 3;
  localparam int A2 = 4;
  localparam int NUM_COEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Guard bits cover the five-term sum of full-scale products.
  function automatic int acc_width(input int w, input int cw);
    return w + cw + 3;
  endfunction

  localparam int ACC_WIDTH_DEFAULT = acc_width(16, 16);

  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int w,
                                                  output logic clip);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    clip = 1'b0;
    saturate = v;
    if (v > hi) begin
      saturate = hi;
      clip = 1'b1;
    end else if (v < lo) begin
      saturate = lo;
      clip = 1'b1;
    end
  endfunction

endpackage

// File: rtl/biquad_section_dp.sv
// Combinational Direct Form I section: MAC, truncating shift, then wrap or clip.
// With BIQUAD_SAT_EN defined the result saturates and a clip indication is produced.
module biquad_section_dp
  import biquad_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int COEF_WIDTH = 16,
  parameter int COEF_FRAC  = 14
) (
  input  logic signed [WIDTH-1:0]      x,
  input  logic signed [WIDTH-1:0]      x1,
  input  logic signed [WIDTH-1:0]      x2,
  input  logic signed [WIDTH-1:0]      y1,
  input  logic signed [WIDTH-1:0]      y2,
  input  logic signed [COEF_WIDTH-1:0] b0,
  input  logic signed [COEF_WIDTH-1:0] b1,
  input  logic signed [COEF_WIDTH-1:0] b2,
  input  logic signed [COEF_WIDTH-1:0] a1,
  input  logic signed [COEF_WIDTH-1:0] a2,
  output logic signed [WIDTH-1:0]      y
`ifdef BIQUAD_SAT_EN
  ,
  output logic                         clip
`endif
);

  localparam int ACC_W = acc_width(WIDTH, COEF_WIDTH);

  logic signed [ACC_W-1:0] s_x, s_x1, s_x2, s_y1, s_y2;
  logic signed [ACC_W-1:0] c_b0, c_b1, c_b2, c_a1, c_a2;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] shifted;
`ifdef BIQUAD_SAT_EN
  logic signed [63:0] wide;
  logic signed [63:0] clipped;
`endif

  always_comb begin
    s_x  = ACC_W'(x);
    s_x1 = ACC_W'(x1);
    s_x2 = ACC_W'(x2);
    s_y1 = ACC_W'(y1);
    s_y2 = ACC_W'(y2);
    c_b0 = ACC_W'(b0);
    c_b1 = ACC_W'(b1);
    c_b2 = ACC_W'(b2);
    c_a1 = ACC_W'(a1);
    c_a2 = ACC_W'(a2);
    acc = c_b0 * s_x + c_b1 * s_x1 + c_b2 * s_x2 - c_a1 * s_y1 - c_a2 * s_y2;
    shifted = acc >>> COEF_FRAC;
`ifdef BIQUAD_SAT_EN
    clip = 1'b0;
    wide = 64'(shifted);
    clipped = saturate(wide, WIDTH, clip);
    y = WIDTH'(clipped);
`else
    y = WIDTH'(shifted);
`endif
  end

endmodule

// File: rtl/biquad_cascade.sv
// Time-multiplexed cascade of Direct Form I biquads sharing one section datapath.
// Optional BIQUAD_SAT_EN: saturating sections plus a sticky sat_flag output.
module biquad_cascade
  import biquad_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int COEF_WIDTH   = 16,
  parameter int COEF_FRAC    = 14,
  parameter int NUM_SECTIONS = 2
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic                  EN,
  input  logic                  bypass,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      x_n,
  output logic [WIDTH-1:0]      y_n,
  output logic                  out_valid,
  input  logic                  coef_we,
  input  logic [5:0]            coef_addr,
  input  logic [COEF_WIDTH-1:0] coef_data,
  input  logic                  clear_state
`ifdef BIQUAD_SAT_EN
  ,
  output logic                  sat_flag
`endif
);

  localparam int NUM_COEFS = NUM_COEF * NUM_SECTIONS;
  localparam int CNT_W     = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1;
  localparam int CA_W      = $clog2(NUM_COEFS);
  localparam logic [COEF_WIDTH-1:0] COEF_ONE = {{(COEF_WIDTH-1){1'b0}}, 1'b1} << COEF_FRAC;

  state_e state_q, state_d;

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [WIDTH-1:0] x_cur_q, x_cur_d;
  logic                    byp_q, byp_d;
  logic [WIDTH-1:0]        y_n_q, y_n_d;
  logic                    out_valid_q, out_valid_d;

  logic signed [COEF_WIDTH-1:0] coef_q [NUM_COEFS];
  logic signed [COEF_WIDTH-1:0] coef_d [NUM_COEFS];
  logic signed [WIDTH-1:0] x1_q [NUM_SECTIONS];
  logic signed [WIDTH-1:0] x1_d [NUM_SECTIONS];
  logic signed [WIDTH-1:0] x2_q [NUM_SECTIONS];
  logic signed [WIDTH-1:0] x2_d [NUM_SECTIONS];
  logic signed [WIDTH-1:0] y1_q [NUM_SECTIONS];
  logic signed [WIDTH-1:0] y1_d [NUM_SECTIONS];
  logic signed [WIDTH-1:0] y2_q [NUM_SECTIONS];
  logic signed [WIDTH-1:0] y2_d [NUM_SECTIONS];

  logic accept, do_clear, coef_wr, step, upd;

  logic [CA_W-1:0]              base;
  logic signed [WIDTH-1:0]      sec_x1, sec_x2, sec_y1, sec_y2, sec_y;
  logic signed [COEF_WIDTH-1:0] sec_b0, sec_b1, sec_b2, sec_a1, sec_a2;

`ifdef BIQUAD_SAT_EN
  logic sec_clip;
  logic sat_flag_q, sat_flag_d;
`endif

  // FSM: state register
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (EN) begin
      case (state_q)
        ST_IDLE: if (accept) state_d = ST_RUN;
        ST_RUN:  if (cnt_q == CNT_W'(NUM_SECTIONS - 1)) state_d = ST_DONE;
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM: outputs; clear wins over a simultaneous accept
  always_comb begin
    in_ready = (state_q == ST_IDLE) && EN;
    do_clear = in_ready && clear_state;
    accept   = in_ready && in_valid && !clear_state;
    coef_wr  = in_ready && coef_we && (coef_addr < 6'(NUM_COEFS));
    step     = EN && (state_q == ST_RUN);
    upd      = step && !byp_q;
  end

  always_comb begin
    base   = CA_W'(cnt_q) * CA_W'(NUM_COEF);
    sec_x1 = x1_q[cnt_q];
    sec_x2 = x2_q[cnt_q];
    sec_y1 = y1_q[cnt_q];
    sec_y2 = y2_q[cnt_q];
    sec_b0 = coef_q[base + CA_W'(B0)];
    sec_b1 = coef_q[base + CA_W'(B1)];
    sec_b2 = coef_q[base + CA_W'(B2)];
    sec_a1 = coef_q[base + CA_W'(A1)];
    sec_a2 = coef_q[base + CA_W'(A2)];
  end

  biquad_section_dp #(
    .WIDTH      (WIDTH),
    .COEF_WIDTH (COEF_WIDTH),
    .COEF_FRAC  (COEF_FRAC)
  ) u_dp (
    .x    (x_cur_q),
    .x1   (sec_x1),
    .x2   (sec_x2),
    .y1   (sec_y1),
    .y2   (sec_y2),
    .b0   (sec_b0),
    .b1   (sec_b1),
    .b2   (sec_b2),
    .a1   (sec_a1),
    .a2   (sec_a2),
    .y    (sec_y)
`ifdef BIQUAD_SAT_EN
    ,
    .clip (sec_clip)
`endif
  );

  always_comb begin
    cnt_d       = cnt_q;
    x_cur_d     = x_cur_q;
    byp_d       = byp_q;
    y_n_d       = y_n_q;
    out_valid_d = out_valid_q;
    coef_d      = coef_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    y1_d        = y1_q;
    y2_d        = y2_q;

    if (accept) begin
      cnt_d   = '0;
      x_cur_d = x_n;
      byp_d   = bypass;
    end
    // A bypassed sample rides through RUN unchanged so latency matches.
    if (step) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (!byp_q) x_cur_d = sec_y;
    end
    if (EN) begin
      out_valid_d = (state_q == ST_DONE);
      if (state_q == ST_DONE) y_n_d = x_cur_q;
    end

    if (coef_wr) begin
      for (int i = 0; i < NUM_COEFS; i++) begin
        if (coef_addr == 6'(i)) coef_d[i] = coef_data;
      end
    end

    for (int s = 0; s < NUM_SECTIONS; s++) begin
      if (do_clear) begin
        x1_d[s] = '0;
        x2_d[s] = '0;
        y1_d[s] = '0;
        y2_d[s] = '0;
      end else if (upd && (cnt_q == CNT_W'(s))) begin
        x2_d[s] = x1_q[s];
        x1_d[s] = x_cur_q;
        y2_d[s] = y1_q[s];
        y1_d[s] = sec_y;
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      x_cur_q     <= '0;
      byp_q       <= 1'b0;
      y_n_q       <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < NUM_COEFS; i++) begin
        coef_q[i] <= ((i % NUM_COEF) == B0) ? COEF_ONE : '0;
      end
      for (int s = 0; s < NUM_SECTIONS; s++) begin
        x1_q[s] <= '0;
        x2_q[s] <= '0;
        y1_q[s] <= '0;
        y2_q[s] <= '0;
      end
    end else begin
      cnt_q       <= cnt_d;
      x_cur_q     <= x_cur_d;
      byp_q       <= byp_d;
      y_n_q       <= y_n_d;
      out_valid_q <= out_valid_d;
      coef_q      <= coef_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      y1_q        <= y1_d;
      y2_q        <= y2_d;
    end
  end

`ifdef BIQUAD_SAT_EN
  always_comb begin
    sat_flag_d = sat_flag_q | (upd & sec_clip);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      sat_flag_q <= 1'b0;
    end else begin
      sat_flag_q <= sat_flag_d;
    end
  end

  assign sat_flag = sat_flag_q;
`endif

  assign y_n       = y_n_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_biquad_cascade.sv
// Directed self-checking bench for biquad_cascade (default parameters, N = 2).
module tb_biquad_cascade;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        EN;
  logic        bypass;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x_n;
  logic [15:0] y_n;
  logic        out_valid;
  logic        coef_we;
  logic [5:0]  coef_addr;
  logic [15:0] coef_data;
  logic        clear_state;
`ifdef BIQUAD_SAT_EN
  logic        sat_flag;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  biquad_cascade dut (
    .CLK         (CLK),
    .rst_n       (rst_n),
    .EN          (EN),
    .bypass      (bypass),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .x_n         (x_n),
    .y_n         (y_n),
    .out_valid   (out_valid),
    .coef_we     (coef_we),
    .coef_addr   (coef_addr),
    .coef_data   (coef_data),
    .clear_state (clear_state)
`ifdef BIQUAD_SAT_EN
    ,
    .sat_flag    (sat_flag)
`endif
  );

  task automatic write_coef(input logic [5:0] addr, input logic [15:0] data);
    @(negedge CLK);
    coef_we = 1'b1; coef_addr = addr; coef_data = data;
    @(negedge CLK);
    coef_we = 1'b0;
    $display("coef write addr=%0d data=%h", addr, data);
  endtask

  task automatic do_clear();
    @(negedge CLK);
    clear_state = 1'b1;
    @(negedge CLK);
    clear_state = 1'b0;
  endtask

  // lat = edges after the accept edge until out_valid is seen; -1 on timeout
  task automatic send(input logic [15:0] x, input logic byp, output logic [15:0] y, output int lat);
    @(negedge CLK);
    in_valid = 1'b1; x_n = x; bypass = byp;
    @(negedge CLK);
    in_valid = 1'b0; bypass = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    if (!out_valid) lat = -1;
    y = y_n;
    $display("txn x=%h bypass=%0d y=%h lat=%0d", x, byp, y, lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; EN = 1'b1; bypass = 1'b0; in_valid = 1'b0; x_n = '0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0; clear_state = 1'b0;
    #12;
    checks++; if (y_n !== 16'h0000) begin errors++; $display("FAIL reset_y_n: got %h want 0000", y_n); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
`ifdef BIQUAD_SAT_EN
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat_flag: got %b want 0", sat_flag); end
`endif
    @(negedge CLK);
    rst_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_passthrough();
    logic [15:0] y; int lat;
    send(16'h1234, 1'b0, y, lat);
    checks++; if (y !== 16'h1234) begin errors++; $display("FAIL pass_y: got %h want 1234", y); end
    checks++; if (lat != 3) begin errors++; $display("FAIL pass_latency: got %0d want 3", lat); end
    repeat (2) @(negedge CLK);
    checks++; if (y_n !== 16'h1234) begin errors++; $display("FAIL pass_hold: got %h want 1234", y_n); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pass_strobe_len: got %b want 0", out_valid); end
    send(16'h8001, 1'b0, y, lat);
    checks++; if (y !== 16'h8001) begin errors++; $display("FAIL pass_neg: got %h want 8001", y); end
  endtask

  task automatic test_iir_impulse();
    logic [15:0] y; int lat;
    logic [15:0] exp_v [4];
    exp_v = '{16'h4000, 16'h2000, 16'h1000, 16'h0800};
    write_coef(6'd3, 16'hE000);
    do_clear();
    for (int i = 0; i < 4; i++) begin
      send((i == 0) ? 16'h4000 : 16'h0000, 1'b0, y, lat);
      checks++; if (y !== exp_v[i]) begin errors++; $display("FAIL impulse_%0d: got %h want %h", i, y, exp_v[i]); end
    end
  endtask

  task automatic test_clear_priority();
    logic [15:0] y; int lat; int n;
    @(negedge CLK);
    clear_state = 1'b1; in_valid = 1'b1; x_n = 16'h7000;
    @(negedge CLK);
    clear_state = 1'b0; in_valid = 1'b0;
    n = 0;
    repeat (6) begin
      @(negedge CLK);
      if (out_valid) n++;
    end
    checks++; if (n != 0) begin errors++; $display("FAIL clear_no_accept: got %0d strobes want 0", n); end
    send(16'h0000, 1'b0, y, lat);
    checks++; if (y !== 16'h0000) begin errors++; $display("FAIL clear_state_zero: got %h want 0000", y); end
  endtask

  task automatic test_bypass();
    logic [15:0] y; int lat;
    send(16'h4000, 1'b0, y, lat);
    checks++; if (y !== 16'h4000) begin errors++; $display("FAIL byp_pre: got %h want 4000", y); end
    send(16'h1111, 1'b1, y, lat);
    checks++; if (y !== 16'h1111) begin errors++; $display("FAIL byp_value: got %h want 1111", y); end
    checks++; if (lat != 3) begin errors++; $display("FAIL byp_latency: got %0d want 3", lat); end
    send(16'h0000, 1'b0, y, lat);
    checks++; if (y !== 16'h2000) begin errors++; $display("FAIL byp_state_kept: got %h want 2000", y); end
  endtask

  task automatic test_coef_we_in_run();
    logic [15:0] y; int lat;
    write_coef(6'd3, 16'h0000);
    @(negedge CLK);
    in_valid = 1'b1; x_n = 16'h0100;
    @(negedge CLK);
    in_valid = 1'b0;
    coef_we = 1'b1; coef_addr = 6'd0; coef_data = 16'h2000;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    coef_we = 1'b0;
    $display("txn x=0100 with coef_we in RUN y=%h lat=%0d", y_n, lat);
    checks++; if (y_n !== 16'h0100) begin errors++; $display("FAIL run_write_cur: got %h want 0100", y_n); end
    checks++; if (lat != 3) begin errors++; $display("FAIL run_write_lat: got %0d want 3", lat); end
    send(16'h0100, 1'b0, y, lat);
    checks++; if (y !== 16'h0100) begin errors++; $display("FAIL run_write_dropped: got %h want 0100", y); end
  endtask

  task automatic test_back_to_back();
    int acc_cyc [$];
    int n_out; int bad_val; int bad_gap;
    n_out = 0; bad_val = 0; bad_gap = 0;
    for (int c = 0; c < 18; c++) begin
      @(negedge CLK);
      in_valid = (c <= 12);
      x_n = 16'h0200;
      if (in_ready && in_valid) acc_cyc.push_back(c);
      if (out_valid) begin
        n_out++;
        if (y_n !== 16'h0200) bad_val++;
      end
    end
    in_valid = 1'b0;
    for (int i = 1; i < acc_cyc.size(); i++) begin
      if (acc_cyc[i] - acc_cyc[i-1] != 4) bad_gap++;
    end
    $display("back-to-back accepts=%0d outputs=%0d", acc_cyc.size(), n_out);
    checks++; if (acc_cyc.size() != 4) begin errors++; $display("FAIL b2b_accepts: got %0d want 4", acc_cyc.size()); end
    checks++; if (bad_gap != 0) begin errors++; $display("FAIL b2b_interval: got %0d bad gaps want 0", bad_gap); end
    checks++; if (n_out != 4) begin errors++; $display("FAIL b2b_outputs: got %0d want 4", n_out); end
    checks++; if (bad_val != 0) begin errors++; $display("FAIL b2b_values: got %0d bad want 0", bad_val); end
  endtask

  task automatic test_enable_freeze();
    int n; int lat;
    @(negedge CLK);
    EN = 1'b0; in_valid = 1'b1; x_n = 16'h0321;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL en_in_ready: got %b want 0", in_ready); end
    n = 0;
    repeat (3) begin
      @(negedge CLK);
      if (out_valid) n++;
    end
    EN = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0; EN = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      if (out_valid) n++;
    end
    checks++; if (n != 0) begin errors++; $display("FAIL en_frozen: got %0d strobes want 0", n); end
    EN = 1'b1;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    $display("txn x=0321 with EN freeze y=%h lat=%0d", y_n, lat);
    checks++; if (lat != 3) begin errors++; $display("FAIL en_resume_lat: got %0d want 3", lat); end
    checks++; if (y_n !== 16'h0321) begin errors++; $display("FAIL en_value: got %h want 0321", y_n); end
  endtask

  task automatic test_saturation();
    logic [15:0] y; int lat;
    write_coef(6'd0, 16'h7FFF);
    send(16'h7FFF, 1'b0, y, lat);
`ifdef BIQUAD_SAT_EN
    checks++; if (y !== 16'h7FFF) begin errors++; $display("FAIL sat_value: got %h want 7fff", y); end
    checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_flag: got %b want 1", sat_flag); end
`else
    checks++; if (y !== 16'hFFFC) begin errors++; $display("FAIL wrap_value: got %h want fffc", y); end
`endif
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] y; int lat; int n;
    write_coef(6'd0, 16'h4000);
    write_coef(6'd3, 16'hE000);
    do_clear();
    send(16'h4000, 1'b0, y, lat);
    checks++; if (y !== 16'h4000) begin errors++; $display("FAIL rst_prime: got %h want 4000", y); end
    @(negedge CLK);
    in_valid = 1'b1; x_n = 16'h1000;
    @(negedge CLK);
    in_valid = 1'b0;
    @(negedge CLK);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (y_n !== 16'h0000) begin errors++; $display("FAIL rst_run_y_n: got %h want 0000", y_n); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_run_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_run_idle: got %b want 1", in_ready); end
`ifdef BIQUAD_SAT_EN
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL rst_run_sat_flag: got %b want 0", sat_flag); end
`endif
    @(negedge CLK);
    rst_n = 1'b1;
    n = 0;
    repeat (6) begin
      @(negedge CLK);
      if (out_valid) n++;
    end
    checks++; if (n != 0) begin errors++; $display("FAIL rst_discard: got %0d strobes want 0", n); end
    write_coef(6'd3, 16'hE000);
    send(16'h4000, 1'b0, y, lat);
    checks++; if (y !== 16'h4000) begin errors++; $display("FAIL rst_zero_state0: got %h want 4000", y); end
    send(16'h0000, 1'b0, y, lat);
    checks++; if (y !== 16'h2000) begin errors++; $display("FAIL rst_zero_state1: got %h want 2000", y); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_iir_impulse();
    test_clear_priority();
    test_bypass();
    test_coef_we_in_run();
    test_back_to_back();
    test_enable_freeze();
    test_saturation();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/biquad_cascade.md
BIQUAD_CASCADE -- requirements
Module: biquad_cascade

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning sample width, signed S16.14 in and out.
REQ-002 SHALL have parameter COEF_WIDTH, default 16, meaning signed coefficient width.
REQ-003 SHALL have parameter COEF_FRAC, default 14, meaning coefficient fractional bits (0x4000 = 1.0).
REQ-004 SHALL have parameter NUM_SECTIONS, default 2, legal range 1..8, meaning number of cascaded biquad sections.
REQ-005 SHALL have port CLK, input, 1 bit: the single clock, rising-edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port EN, input, 1 bit: when low, all state is frozen.
REQ-008 SHALL have port bypass, input, 1 bit: sampled at acceptance.
REQ-009 SHALL have port in_valid, input, 1 bit, and port in_ready, output, 1 bit: the input handshake.
REQ-010 SHALL have port x_n, input, WIDTH bits: the input sample.
REQ-011 SHALL have port y_n, output, WIDTH bits, and port out_valid, output, 1 bit: the result and a one-cycle strobe.
REQ-012 SHALL have port coef_we, input, 1 bit; coef_addr, input, 6 bits; coef_data, input, COEF_WIDTH bits: the coefficient write port.
REQ-013 SHALL have port clear_state, input, 1 bit: clears the delay lines.
REQ-014 SHALL have port sat_flag, output, 1 bit: sticky overflow flag; present only with BIQUAD_SAT_EN.

Function
REQ-015 SHALL compute each section in Direct Form I: y = b0·x + b1·x1 + b2·x2 − a1·y1 − a2·y2.
REQ-016 SHALL use accumulator width WIDTH+COEF_WIDTH+3, arithmetic right shift by COEF_FRAC (truncation), then resize to WIDTH.
REQ-017 SHALL index coefficients as coef_addr = 5·section + k, with k order b0, b1, b2, a1, a2; addresses ≥ 5·NUM_SECTIONS are ignored.
REQ-018 SHALL use a state machine IDLE → RUN → DONE → IDLE; in_ready = 1 only in IDLE with EN = 1.
REQ-019 SHALL, on in_valid & in_ready at edge t0, latch x_n and bypass and enter RUN with section counter 0.
REQ-020 SHALL, in RUN, evaluate section[cnt] in one cycle, feed its output to section cnt+1, update that section's delay lines, and go to DONE when cnt = NUM_SECTIONS−1.
REQ-021 SHALL, in DONE, assert out_valid for exactly one cycle with y_n registered; out_valid is high between edges t0+N+1 and t0+N+2, giving an accept interval of N+2 cycles.
REQ-022 SHALL, with latched bypass = 1, make y_n equal the latched x_n with identical latency and leave delay lines untouched.
REQ-023 SHALL hold y_n between strobes.
REQ-024 SHALL accept coef_we only in IDLE; writes in RUN or DONE are dropped with no effect.
REQ-025 SHALL act on clear_state only in IDLE, zeroing all delay lines in one cycle; when clear_state and an accept occur together, clear takes priority and the input is not accepted.
REQ-026 SHALL, with EN = 0, freeze the state, counter, delay lines and out_valid level, with in_ready = 0.

Reset
REQ-027 SHALL, on rst_n low at any time including mid-RUN, immediately go to IDLE with y_n = 0, out_valid = 0, delay lines = 0, sat_flag = 0; the in-flight sample is discarded.
REQ-028 SHALL reset the coefficients to pass-through: b0 = 0x4000, all others 0.

Configuration
REQ-029 SHALL, with BIQUAD_SAT_EN defined, saturate every section result to [−2^(WIDTH−1), 2^(WIDTH−1)−1] and set sat_flag on any clip (cleared only by reset).
REQ-030 SHALL, without BIQUAD_SAT_EN, wrap results (two's-complement truncation) and omit the sat_flag port.

Structure
REQ-031 SHALL place in package biquad_pkg: the coefficient-index constants (B0..A2), the state enum, the accumulator-width constant and the saturate function.
REQ-032 SHALL implement one sub-module, biquad_section_dp: combinational single-section MAC/shift/saturate, instantiated once and time-multiplexed.

Verification
REQ-033 SHALL cover: reset coefficients, N = 2, x_n = 0x1234 → y_n = 0x1234 with out_valid 3 cycles after acceptance.
REQ-034 SHALL cover: section0 a1 = 0xE000 (−0.5), impulse 0x4000 → outputs 0x4000, 0x2000, 0x1000, 0x0800.
REQ-035 SHALL cover: b0 = 0x7FFF, x_n = 0x7FFF → 0x7FFF with sat_flag = 1 under the macro, wrapped value without it.
REQ-036 SHALL cover: in_valid held high → accepts exactly every 4 cycles (N = 2); coef_we during RUN → coefficients unchanged.
REQ-037 SHALL cover: rst_n pulsed during RUN → no out_valid, all outputs 0, next sample processed from zero state.
REQ-038 SHALL cover: bypass = 1 with a nonzero filter → y_n = x_n, and delay lines are unchanged on the next filtered sample.
